// File: rtl/wb_regfile_pkg.sv
// Shared writeback/register-file constants and types.
// Also used by the pipeline registers and the hazard unit.
package wb_regfile_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

  // A write only commits when enabled and not aimed at the hardwired x0.
  function automatic logic wb_commits(logic reg_write, reg_idx_t rd);
    return reg_write && (rd != ZERO_REG);
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus plus the decode-stage read ports and writeback observability.
// The master side is the pipeline/ID stage; the slave side is wb_regfile.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int unsigned CNT_W = 64
);

  logic             RegWriteW;
  logic             MemToRegW;
  xlen_t            ReadDataW;
  xlen_t            ALU_ResultW;
  reg_idx_t         RD_W;
  reg_idx_t         RS1_D;
  reg_idx_t         RS2_D;
  xlen_t            RD1_D;
  xlen_t            RD2_D;
  xlen_t            ResultW;
  logic [CNT_W-1:0] WbCount;

  modport master (
    output RegWriteW, MemToRegW, ReadDataW, ALU_ResultW, RD_W, RS1_D, RS2_D,
    input  RD1_D, RD2_D, ResultW, WbCount
  );

  modport slave (
    input  RegWriteW, MemToRegW, ReadDataW, ALU_ResultW, RD_W, RS1_D, RS2_D,
    output RD1_D, RD2_D, ResultW, WbCount
  );

endinterface

// File: rtl/wb_result_mux.sv
// Writeback result select: load data when sel is set, otherwise the ALU result.
module wb_result_mux
  import wb_regfile_pkg::*;
(
  input  logic  sel,
  input  xlen_t mem_data,
  input  xlen_t alu_data,
  output xlen_t result
);

  assign result = sel ? mem_data : alu_data;

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 x 64-bit, x0 hardwired, two async read ports, commit counter.
// Define WB_BYPASS_EN to make same-cycle reads of the register being written return ResultW.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  xlen_t            result;
  logic             commit;
  xlen_t            regs_q [NREGS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  xlen_t            rd1, rd2;

  wb_result_mux u_result_mux (
    .sel      (bus.MemToRegW),
    .mem_data (bus.ReadDataW),
    .alu_data (bus.ALU_ResultW),
    .result   (result)
  );

  assign commit = wb_commits(bus.RegWriteW, bus.RD_W);

  // Counter wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (commit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Entry 0 is never written after reset; reads of x0 are masked below.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      if (commit) begin
        regs_q[bus.RD_W] <= result;
      end
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rd1 = '0;
    if (bus.RS1_D != ZERO_REG) begin
      rd1 = regs_q[bus.RS1_D];
`ifdef WB_BYPASS_EN
      if (commit && (bus.RS1_D == bus.RD_W)) begin
        rd1 = result;
      end
`endif
    end
  end

  always_comb begin
    rd2 = '0;
    if (bus.RS2_D != ZERO_REG) begin
      rd2 = regs_q[bus.RS2_D];
`ifdef WB_BYPASS_EN
      if (commit && (bus.RS2_D == bus.RD_W)) begin
        rd2 = result;
      end
`endif
    end
  end

  assign bus.RD1_D   = rd1;
  assign bus.RD2_D   = rd2;
  assign bus.ResultW = result;
  assign bus.WbCount = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; a second instance with a 4-bit counter checks wrap.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wb_regfile_if #(.CNT_W(64)) bus ();
  wb_regfile_if #(.CNT_W(4))  bus4 ();

  wb_regfile #(.CNT_W(64)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wb_regfile #(.CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.RegWriteW   = 1'b0;
    bus.MemToRegW   = 1'b0;
    bus.ReadDataW   = '0;
    bus.ALU_ResultW = '0;
    bus.RD_W        = '0;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.RegWriteW   = 1'b1;
    bus.MemToRegW   = 1'b0;
    bus.ALU_ResultW = 64'hAA;
    bus.RD_W        = 5'd5;
    bus.RS1_D       = 5'd5;
    bus.RS2_D       = 5'd17;
    tick();
    tick();
    n_cmp++;
    if (bus.WbCount !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_count: got %0d want 0", bus.WbCount);
    end
    n_cmp++;
    if (bus.RD1_D !== 64'd0 || bus.RD2_D !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_reads: got %h/%h want 0/0", bus.RD1_D, bus.RD2_D);
    end
    n_cmp++;
    if (bus.ResultW !== 64'hAA) begin
      n_bad++;
      $display("FAIL reset_resultw: got %h want aa", bus.ResultW);
    end
    idle();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (bus.RD1_D !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_x5_after: got %h want 0", bus.RD1_D);
    end
  endtask

  task automatic test_alu_wb();
    bus.RegWriteW   = 1'b1;
    bus.MemToRegW   = 1'b0;
    bus.ReadDataW   = 64'hFFFF_0000_FFFF_0000;
    bus.ALU_ResultW = 64'h1234;
    bus.RD_W        = 5'd3;
    #1;
    n_cmp++;
    if (bus.ResultW !== 64'h1234) begin
      n_bad++;
      $display("FAIL alu_resultw: got %h want 1234", bus.ResultW);
    end
    tick();
    idle();
    bus.RS1_D = 5'd3;
    #1;
    n_cmp++;
    if (bus.RD1_D !== 64'h1234) begin
      n_bad++;
      $display("FAIL alu_x3: got %h want 1234", bus.RD1_D);
    end
    n_cmp++;
    if (bus.WbCount !== 64'd1) begin
      n_bad++;
      $display("FAIL alu_count: got %0d want 1", bus.WbCount);
    end
  endtask

  task automatic test_load_wb();
    bus.RegWriteW   = 1'b1;
    bus.MemToRegW   = 1'b1;
    bus.ReadDataW   = 64'hDEADBEEF_00000001;
    bus.ALU_ResultW = 64'h55;
    bus.RD_W        = 5'd31;
    #1;
    n_cmp++;
    if (bus.ResultW !== 64'hDEADBEEF_00000001) begin
      n_bad++;
      $display("FAIL load_resultw: got %h want deadbeef00000001", bus.ResultW);
    end
    tick();
    bus.RegWriteW = 1'b0;
    bus.MemToRegW = 1'b0;
    bus.RS2_D     = 5'd31;
    #1;
    n_cmp++;
    if (bus.RD2_D !== 64'hDEADBEEF_00000001) begin
      n_bad++;
      $display("FAIL load_x31: got %h want deadbeef00000001", bus.RD2_D);
    end
    // Mux must follow inputs even with RegWriteW low.
    n_cmp++;
    if (bus.ResultW !== 64'h55) begin
      n_bad++;
      $display("FAIL load_resultw_nowe: got %h want 55", bus.ResultW);
    end
    n_cmp++;
    if (bus.WbCount !== 64'd2) begin
      n_bad++;
      $display("FAIL load_count: got %0d want 2", bus.WbCount);
    end
    idle();
  endtask

  task automatic test_x0();
    bus.RegWriteW   = 1'b1;
    bus.ALU_ResultW = 64'hFFFF;
    bus.RD_W        = 5'd0;
    bus.RS1_D       = 5'd0;
    bus.RS2_D       = 5'd0;
    #1;
    n_cmp++;
    if (bus.RD1_D !== 64'd0 || bus.RD2_D !== 64'd0) begin
      n_bad++;
      $display("FAIL x0_pre_edge: got %h/%h want 0/0", bus.RD1_D, bus.RD2_D);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.RD1_D !== 64'd0 || bus.RD2_D !== 64'd0) begin
      n_bad++;
      $display("FAIL x0_read: got %h/%h want 0/0", bus.RD1_D, bus.RD2_D);
    end
    n_cmp++;
    if (bus.WbCount !== 64'd2) begin
      n_bad++;
      $display("FAIL x0_count: got %0d want 2", bus.WbCount);
    end
  endtask

  task automatic test_hazard();
    logic [63:0] exp_pre;
`ifdef WB_BYPASS_EN
    exp_pre = 64'h20;
`else
    exp_pre = 64'h10;
`endif
    bus.RegWriteW   = 1'b1;
    bus.ALU_ResultW = 64'h10;
    bus.RD_W        = 5'd7;
    tick();
    bus.ALU_ResultW = 64'h20;
    bus.RS1_D       = 5'd7;
    bus.RS2_D       = 5'd7;
    #1;
    n_cmp++;
    if (bus.RD1_D !== exp_pre || bus.RD2_D !== exp_pre) begin
      n_bad++;
      $display("FAIL hazard_pre_edge: got %h/%h want %h", bus.RD1_D, bus.RD2_D, exp_pre);
    end
    // Unrelated port index must still see stored data while x7 is written.
    bus.RS2_D = 5'd3;
    #1;
    n_cmp++;
    if (bus.RD2_D !== 64'h1234) begin
      n_bad++;
      $display("FAIL hazard_other_port: got %h want 1234", bus.RD2_D);
    end
    bus.RS2_D = 5'd7;
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.RD1_D !== 64'h20 || bus.RD2_D !== 64'h20) begin
      n_bad++;
      $display("FAIL hazard_post_edge: got %h/%h want 20/20", bus.RD1_D, bus.RD2_D);
    end
    n_cmp++;
    if (bus.WbCount !== 64'd4) begin
      n_bad++;
      $display("FAIL hazard_count: got %0d want 4", bus.WbCount);
    end
  endtask

  task automatic test_reset_midstream();
    reset           = 1'b1;
    bus.RegWriteW   = 1'b1;
    bus.ALU_ResultW = 64'h99;
    bus.RD_W        = 5'd9;
    tick();
    reset           = 1'b0;
    bus.ALU_ResultW = 64'h77;
    tick();
    idle();
    bus.RS1_D = 5'd9;
    bus.RS2_D = 5'd3;
    #1;
    n_cmp++;
    if (bus.RD1_D !== 64'h77) begin
      n_bad++;
      $display("FAIL midreset_x9: got %h want 77", bus.RD1_D);
    end
    n_cmp++;
    if (bus.RD2_D !== 64'd0) begin
      n_bad++;
      $display("FAIL midreset_x3_cleared: got %h want 0", bus.RD2_D);
    end
    n_cmp++;
    if (bus.WbCount !== 64'd1) begin
      n_bad++;
      $display("FAIL midreset_count: got %0d want 1", bus.WbCount);
    end
  endtask

  task automatic test_wrap();
    bus4.RegWriteW = 1'b1;
    bus4.RD_W      = 5'd1;
    for (int i = 1; i <= 17; i++) begin
      bus4.ALU_ResultW = 64'(i);
      tick();
      if (i == 16) begin
        n_cmp++;
        if (bus4.WbCount !== 4'd0) begin
          n_bad++;
          $display("FAIL wrap_at_16: got %0d want 0", bus4.WbCount);
        end
      end
    end
    bus4.RegWriteW = 1'b0;
    bus4.RS1_D     = 5'd1;
    #1;
    n_cmp++;
    if (bus4.WbCount !== 4'd1) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d want 1", bus4.WbCount);
    end
    n_cmp++;
    if (bus4.RD1_D !== 64'd17) begin
      n_bad++;
      $display("FAIL wrap_x1: got %0d want 17", bus4.RD1_D);
    end
  endtask

  initial begin
    reset            = 1'b1;
    idle();
    bus.RS1_D        = '0;
    bus.RS2_D        = '0;
    bus4.RegWriteW   = 1'b0;
    bus4.MemToRegW   = 1'b0;
    bus4.ReadDataW   = '0;
    bus4.ALU_ResultW = '0;
    bus4.RD_W        = '0;
    bus4.RS1_D       = '0;
    bus4.RS2_D       = '0;
    @(negedge clk);
    test_reset();
    test_alu_wb();
    test_load_wb();
    test_x0();
    test_hazard();
    test_reset_midstream();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
